// File: rtl/fpna_cfg_loader_if.sv
// Serial configuration bus between the pin-level stream source and fpna_cfg_loader.
// P is the payload width (CELLS*CELL_BITS) and must match the loader instance.
interface fpna_cfg_loader_if #(
   parameter int P = 32
);
   logic          config_en;
   logic          bs_in;
   logic          bs_out;
   logic [P-1:0]  cfg_out;
   logic          cfg_valid;
   logic          frame_err;
   logic          commit;

   modport master (
      output config_en,
      output bs_in,
      input  bs_out,
      input  cfg_out,
      input  cfg_valid,
      input  frame_err,
      input  commit
   );

   modport slave (
      input  config_en,
      input  bs_in,
      output bs_out,
      output cfg_out,
      output cfg_valid,
      output frame_err,
      output commit
   );
endinterface

// File: rtl/fpna_cfg_loader.sv
// Bit-serial configuration loader: shift chain, length/parity check, shadowed commit to cfg_out.
// Define CFG_PARITY_EN to append and check an even-parity bit at the end of each frame.
module fpna_cfg_loader #(
   parameter int CELLS     = 4,
   parameter int CELL_BITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   fpna_cfg_loader_if.slave bus
);
   localparam int P = CELLS * CELL_BITS;
`ifdef CFG_PARITY_EN
   localparam int L = P + 1;
`else
   localparam int L = P;
`endif
   localparam int CW = $clog2(L + 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(L);
   localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [L-1:0]    chain_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt_s;
   logic            shift_s;
   logic            check_s;
   logic            frame_ok_s;
   logic [P-1:0]    payload_s;
   logic [P-1:0]    cfg_out_r;
   logic            bs_out_r;
   logic            cfg_valid_r;
   logic            frame_err_r;
   logic            commit_r;

`ifdef CFG_PARITY_EN
   function automatic logic parity_ok(input logic [L-1:0] v);
      return ((^v) == 1'b0);
   endfunction

   assign frame_ok_s = (count_r == CNT_FULL) && parity_ok(chain_r);
   assign payload_s  = chain_r[L-1:1];
`else
   assign frame_ok_s = (count_r == CNT_FULL);
   assign payload_s  = chain_r[L-1:0];
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, shift enable and saturating bit count; COMMIT never shifts
   always_comb begin
      state_nxt_s = state_r;
      shift_s     = 1'b0;
      check_s     = 1'b0;
      count_nxt_s = count_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.config_en) begin
               shift_s     = 1'b1;
               count_nxt_s = CNT_ONE;
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bus.config_en) begin
               shift_s = 1'b1;
               if (count_r == CNT_SAT) begin
                  count_nxt_s = CNT_SAT;
               end else begin
                  count_nxt_s = count_r + CNT_ONE;
               end
            end else begin
               state_nxt_s = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            check_s     = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Shift chain, bit counter and readback tap (old MSB leaves on each shift)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_r  <= {L{1'b0}};
         count_r  <= {CW{1'b0}};
         bs_out_r <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (shift_s) begin
            chain_r  <= {chain_r[L-2:0], bus.bs_in};
            bs_out_r <= chain_r[L-1];
         end
      end
   end

   // Commit stage: only a fully checked frame reaches the cell array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_out_r   <= {P{1'b0}};
         cfg_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
         commit_r    <= 1'b0;
      end else if (check_s) begin
         if (frame_ok_s) begin
            cfg_out_r   <= payload_s;
            cfg_valid_r <= 1'b1;
            frame_err_r <= 1'b0;
            commit_r    <= 1'b1;
         end else begin
            frame_err_r <= 1'b1;
            commit_r    <= 1'b0;
         end
      end else begin
         commit_r <= 1'b0;
      end
   end

   assign bus.bs_out    = bs_out_r;
   assign bus.cfg_out   = cfg_out_r;
   assign bus.cfg_valid = cfg_valid_r;
   assign bus.frame_err = frame_err_r;
   assign bus.commit    = commit_r;
endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Directed bench for fpna_cfg_loader (CELLS=4, CELL_BITS=8); parity cases when CFG_PARITY_EN is defined.
module tb_fpna_cfg_loader;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   commit_cnt;
   int   base;
   logic [31:0] rb_word;

   fpna_cfg_loader_if #(.P(32)) bus ();

   fpna_cfg_loader #(.CELLS(4), .CELL_BITS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.commit === 1'b1) commit_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [63:0] data, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.config_en = 1'b1;
         bus.bs_in     = data[i];
         tick();
      end
      bus.config_en = 1'b0;
      bus.bs_in     = 1'b0;
   endtask

   // Two edges after the last shift: SHIFT->COMMIT, COMMIT->IDLE
   task automatic close_frame();
      tick();
      check_eq("commit_low_in_commit_state", bus.commit, 1'b0);
      tick();
   endtask

   initial begin
      n_checks = 0; n_fail = 0; commit_cnt = 0;
      rst_n = 1'b0; bus.config_en = 1'b0; bus.bs_in = 1'b0;
      tick(); tick();
      check_eq("rst_cfg_out", bus.cfg_out, 32'h0);
      check_eq("rst_bs_out", bus.bs_out, 1'b0);
      check_eq("rst_cfg_valid", bus.cfg_valid, 1'b0);
      check_eq("rst_frame_err", bus.frame_err, 1'b0);
      check_eq("rst_commit", bus.commit, 1'b0);
      rst_n = 1'b1;
      tick();

`ifdef CFG_PARITY_EN
      base = commit_cnt;
      send_frame({31'd0, 32'hA5C30F81, 1'b0}, 33);
      close_frame();
      check_eq("par_good_cfg_out", bus.cfg_out, 32'hA5C30F81);
      check_eq("par_good_commit", bus.commit, 1'b1);
      check_eq("par_good_frame_err", bus.frame_err, 1'b0);
      check_eq("par_good_valid", bus.cfg_valid, 1'b1);
      tick(); tick();
      send_frame({31'd0, 32'h5A5A5A5A, 1'b1}, 33);
      close_frame();
      check_eq("par_bad_frame_err", bus.frame_err, 1'b1);
      check_eq("par_bad_cfg_out", bus.cfg_out, 32'hA5C30F81);
      check_eq("par_bad_commit", bus.commit, 1'b0);
      tick();
      check_eq("par_commit_count", commit_cnt - base, 1);
`else
      // Good frame
      base = commit_cnt;
      send_frame(64'hA5C30F81, 32);
      tick();
      check_eq("good_cfg_out_before_commit", bus.cfg_out, 32'h0);
      check_eq("good_commit_edge1", bus.commit, 1'b0);
      tick();
      check_eq("good_cfg_out", bus.cfg_out, 32'hA5C30F81);
      check_eq("good_commit", bus.commit, 1'b1);
      check_eq("good_cfg_valid", bus.cfg_valid, 1'b1);
      check_eq("good_frame_err", bus.frame_err, 1'b0);
      tick();
      check_eq("good_commit_one_cycle", bus.commit, 1'b0);
      check_eq("good_commit_count", commit_cnt - base, 1);
      tick();

      // Short frame
      base = commit_cnt;
      send_frame(64'h12345678, 31);
      close_frame();
      check_eq("short_frame_err", bus.frame_err, 1'b1);
      check_eq("short_cfg_out", bus.cfg_out, 32'hA5C30F81);
      check_eq("short_cfg_valid", bus.cfg_valid, 1'b1);
      tick();
      check_eq("short_no_commit", commit_cnt - base, 0);
      tick();

      // Long frame, counter saturates at L+1
      base = commit_cnt;
      send_frame(64'h00_00FF_00FF_00FF, 40);
      check_eq("long_count_sat", dut.count_r, 33);
      close_frame();
      check_eq("long_frame_err", bus.frame_err, 1'b1);
      check_eq("long_cfg_out", bus.cfg_out, 32'hA5C30F81);
      tick();
      check_eq("long_no_commit", commit_cnt - base, 0);
      tick();

      // Reload, then read back with 32 zeros
      send_frame(64'hA5C30F81, 32);
      close_frame();
      check_eq("reload_cfg_out", bus.cfg_out, 32'hA5C30F81);
      check_eq("reload_frame_err", bus.frame_err, 1'b0);
      tick(); tick();
      rb_word = 32'hA5C30F81;
      for (int k = 31; k >= 0; k--) begin
         bus.config_en = 1'b1;
         bus.bs_in     = 1'b0;
         tick();
         check_eq($sformatf("readback_bit%0d", k), bus.bs_out, rb_word[k]);
      end
      bus.config_en = 1'b0;
      close_frame();
      check_eq("readback_commit_zero", bus.cfg_out, 32'h0);
      check_eq("readback_commit_pulse", bus.commit, 1'b1);
      tick(); tick();

      // Reset mid-frame
      for (int i = 0; i < 16; i++) begin
         bus.config_en = 1'b1;
         bus.bs_in     = 1'b1;
         tick();
      end
      rst_n = 1'b0;
      #1;
      check_eq("midrst_cfg_out", bus.cfg_out, 32'h0);
      check_eq("midrst_cfg_valid", bus.cfg_valid, 1'b0);
      check_eq("midrst_frame_err", bus.frame_err, 1'b0);
      check_eq("midrst_bs_out", bus.bs_out, 1'b0);
      check_eq("midrst_count", dut.count_r, 0);
      bus.config_en = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(64'h12345678, 32);
      close_frame();
      check_eq("after_rst_cfg_out", bus.cfg_out, 32'h12345678);
      check_eq("after_rst_valid", bus.cfg_valid, 1'b1);
      check_eq("after_rst_commit", bus.commit, 1'b1);
      tick(); tick();

      // Back-to-back: config_en high during COMMIT
      base = commit_cnt;
      send_frame(64'h0F0F1234, 32);
      tick();
      bus.config_en = 1'b1;
      bus.bs_in     = 1'b1;
      tick();
      check_eq("b2b_first_cfg_out", bus.cfg_out, 32'h0F0F1234);
      check_eq("b2b_first_commit", bus.commit, 1'b1);
      bus.bs_in = 1'b1;
      tick();
      check_eq("b2b_second_count_start", dut.count_r, 1);
      rb_word = 32'hC3A55A3C;
      for (int k = 30; k >= 0; k--) begin
         bus.config_en = 1'b1;
         bus.bs_in     = rb_word[k];
         tick();
      end
      bus.config_en = 1'b0;
      close_frame();
      check_eq("b2b_second_cfg_out", bus.cfg_out, 32'hC3A55A3C);
      check_eq("b2b_second_frame_err", bus.frame_err, 1'b0);
      tick();
      check_eq("b2b_commit_count", commit_cnt - base, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
